// File: rtl/rng_harvester.sv
// rng_harvester: samples the LHCA generator state, discards a warm-up window,
// XOR-folds DECIM samples per output word and queues the words in a small FIFO
// behind a valid/ready interface.
// Optional macro RNG_RCT_EN adds a repetition-count health test that halts
// output on a stuck source until clr_fail_i is pulsed.
module rng_harvester #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned DECIM         = 4,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned WARMUP_CYCLES = 64,
  parameter int unsigned RCT_LIMIT     = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en_i,
  input  logic [WIDTH-1:0]                     rnd_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [WIDTH-1:0]                     out_data_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level_o,
  output logic                                 health_fail_o,
  input  logic                                 clr_fail_i
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned SW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned WW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WARMUP  = 2'd1;
  localparam logic [1:0] S_COLLECT = 2'd2;
  localparam logic [1:0] S_HALT    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]    samp_cnt_q, samp_cnt_d;
  logic [WW-1:0]    warm_cnt_q, warm_cnt_d;
  logic             warm_done_q, warm_done_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_data_q, pend_data_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             health_fail_q, health_fail_d;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic             pop_c;
  logic             push_c;
  logic             space_c;
  logic [WIDTH-1:0] push_data_c;
  logic [WIDTH-1:0] fold_c;
  logic             rct_fail_c;

`ifdef RNG_RCT_EN
  localparam int unsigned RW = $clog2(RCT_LIMIT + 1);

  logic             sample_c;
  logic [RW-1:0]    rct_cnt_q, rct_cnt_d, rct_next_c;
  logic [WIDTH-1:0] prev_q, prev_d;

  assign sample_c   = en_i && ((state_q == S_WARMUP) ||
                               ((state_q == S_COLLECT) && !pend_valid_q));
  assign rct_fail_c = sample_c && (rct_next_c == RW'(RCT_LIMIT));

  // Repetition count of the sample being taken this cycle
  always_comb begin
    rct_next_c = RW'(1);
    if ((rct_cnt_q != '0) && (rnd_i == prev_q)) rct_next_c = rct_cnt_q + RW'(1);
  end

  // Repetition counter update; cleared whenever sampling stops
  always_comb begin
    rct_cnt_d = rct_cnt_q;
    prev_d    = prev_q;
    if ((state_d == S_IDLE) || (state_d == S_HALT)) begin
      rct_cnt_d = '0;
    end else if (sample_c) begin
      rct_cnt_d = rct_next_c;
      prev_d    = rnd_i;
    end
  end

  // Repetition-count state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rct_cnt_q <= '0;
      prev_q    <= '0;
    end else begin
      rct_cnt_q <= rct_cnt_d;
      prev_q    <= prev_d;
    end
  end
`else
  assign rct_fail_c = 1'b0;
`endif

  assign pop_c   = out_valid_q && out_ready_i;
  assign space_c = (level_q != LW'(FIFO_DEPTH)) || pop_c;
  assign fold_c  = (samp_cnt_q == '0) ? rnd_i
                                      : ({acc_q[WIDTH-2:0], acc_q[WIDTH-1]} ^ rnd_i);

  // Next-state: FSM, folding, pending word and FIFO bookkeeping
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    samp_cnt_d    = samp_cnt_q;
    warm_cnt_d    = warm_cnt_q;
    warm_done_d   = warm_done_q;
    pend_valid_d  = pend_valid_q;
    pend_data_d   = pend_data_q;
    health_fail_d = health_fail_q;
    push_c        = 1'b0;
    push_data_c   = '0;

    // A held word drains first whenever the FIFO can take it
    if (pend_valid_q && space_c && (state_q != S_HALT)) begin
      push_c       = 1'b1;
      push_data_c  = pend_data_q;
      pend_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          state_d = (warm_done_q || (WARMUP_CYCLES == 0)) ? S_COLLECT : S_WARMUP;
        end
      end
      S_WARMUP: begin
        if (!en_i) begin
          state_d    = S_IDLE;
          warm_cnt_d = '0;
        end else if (warm_cnt_q == WW'(WARMUP_CYCLES - 1)) begin
          warm_cnt_d  = '0;
          warm_done_d = 1'b1;
          state_d     = S_COLLECT;
        end else begin
          warm_cnt_d = warm_cnt_q + WW'(1);
        end
      end
      S_COLLECT: begin
        if (!en_i) begin
          state_d    = S_IDLE;
          acc_d      = '0;
          samp_cnt_d = '0;
        end else if (!pend_valid_q) begin
          if (samp_cnt_q == SW'(DECIM - 1)) begin
            samp_cnt_d = '0;
            acc_d      = '0;
            if (space_c) begin
              push_c      = 1'b1;
              push_data_c = fold_c;
            end else begin
              pend_valid_d = 1'b1;
              pend_data_d  = fold_c;
            end
          end else begin
            acc_d      = fold_c;
            samp_cnt_d = samp_cnt_q + SW'(1);
          end
        end
      end
      S_HALT: begin
        if (clr_fail_i) begin
          health_fail_d = 1'b0;
          warm_done_d   = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rd_ptr_d = pop_c  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push_c ? wr_ptr_q + PW'(1) : wr_ptr_q;
    level_d  = level_q + LW'(push_c) - LW'(pop_c);

    // Health fail discards everything buffered and parks in HALT
    if (rct_fail_c) begin
      state_d       = S_HALT;
      health_fail_d = 1'b1;
      push_c        = 1'b0;
      pend_valid_d  = 1'b0;
      acc_d         = '0;
      samp_cnt_d    = '0;
      warm_cnt_d    = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      level_d       = '0;
    end

    // Registered head: bypass the word being written when it becomes the head
    if (level_d == '0)                       head_d = '0;
    else if (push_c && (wr_ptr_q == rd_ptr_d)) head_d = push_data_c;
    else                                     head_d = mem_q[rd_ptr_d];

    out_valid_d = (level_d != '0);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      samp_cnt_q    <= '0;
      warm_cnt_q    <= '0;
      warm_done_q   <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_data_q   <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      level_q       <= '0;
      out_valid_q   <= 1'b0;
      head_q        <= '0;
      health_fail_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      samp_cnt_q    <= samp_cnt_d;
      warm_cnt_q    <= warm_cnt_d;
      warm_done_q   <= warm_done_d;
      pend_valid_q  <= pend_valid_d;
      pend_data_q   <= pend_data_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      level_q       <= level_d;
      out_valid_q   <= out_valid_d;
      head_q        <= head_d;
      health_fail_q <= health_fail_d;
    end
  end

  // FIFO storage; contents only matter where the pointers say they are valid
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= push_data_c;
  end

  assign out_valid_o   = out_valid_q;
  assign out_data_o    = head_q;
  assign fifo_level_o  = level_q;
  assign health_fail_o = health_fail_q;

endmodule

// File: tb/tb_rng_harvester.sv
// Directed self-checking bench for rng_harvester (WARMUP_CYCLES=2, DECIM=4,
// FIFO_DEPTH=4). Covers the RNG_RCT_EN build when that macro is defined.
module tb_rng_harvester;

  logic        clk;
  logic        rst;
  logic        en_i;
  logic [31:0] rnd_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic [2:0]  fifo_level_o;
  logic        health_fail_o;
  logic        clr_fail_i;

  int checks;
  int errors;

  rng_harvester #(
    .WIDTH(32), .DECIM(4), .FIFO_DEPTH(4), .WARMUP_CYCLES(2), .RCT_LIMIT(8)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en_i),
    .rnd_i        (rnd_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .fifo_level_o (fifo_level_o),
    .health_fail_o(health_fail_o),
    .clr_fail_i   (clr_fail_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input logic [31:0] v);
    rnd_i = v;
    step();
  endtask

  // Samples k,0,0,0 fold to 8*k
  task automatic word(input logic [31:0] k);
    samp(k);
    samp(32'h0);
    samp(32'h0);
    samp(32'h0);
  endtask

  initial begin
    logic [31:0] exp_head [5];
    checks = 0;
    errors = 0;
    rst = 1'b0; en_i = 1'b0; rnd_i = '0; out_ready_i = 1'b0; clr_fail_i = 1'b0;

    #3;
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_data",  out_data_o,       32'd0);
    check("rst_level", 32'(fifo_level_o), 32'd0);
    check("rst_fail",  32'(health_fail_o), 32'd0);
    #9 rst = 1'b1;

    // Warm-up discards two samples, then fold of 1,0x10,0x100,0x1000
    out_ready_i = 1'b1;
    en_i = 1'b1;
    step();
    samp(32'hAAAA_0001);
    samp(32'h5555_000F);
    check("t1_warm_level", 32'(fifo_level_o), 32'd0);
    samp(32'h1); samp(32'h10); samp(32'h100);
    check("t1_pre_valid", 32'(out_valid_o), 32'd0);
    samp(32'h1000);
    check("t1_valid", 32'(out_valid_o), 32'd1);
    check("t1_data",  out_data_o,        32'h0000_1248);
    check("t1_level", 32'(fifo_level_o), 32'd1);
    en_i = 1'b0;
    step();
    check("t1_pop_valid", 32'(out_valid_o), 32'd0);
    check("t1_pop_level", 32'(fifo_level_o), 32'd0);
    check("t1_pop_data",  out_data_o,        32'd0);

    // Re-enable after warm-up: partial word discarded, no second warm-up
    en_i = 1'b1;
    step();
    samp(32'hFFFF); samp(32'hEEEE);
    en_i = 1'b0;
    step();
    check("t5_idle_valid", 32'(out_valid_o), 32'd0);
    en_i = 1'b1;
    step();
    samp(32'h1); samp(32'h10); samp(32'h100);
    check("t5_pre_valid", 32'(out_valid_o), 32'd0);
    samp(32'h1000);
    check("t5_data", out_data_o, 32'h0000_1248);
    en_i = 1'b0;
    step();
    check("t5_pop_valid", 32'(out_valid_o), 32'd0);

    // Backpressure: fill, pending word, stall, pop pushes pending on same edge
    out_ready_i = 1'b0;
    en_i = 1'b1;
    step();
    for (int k = 1; k <= 4; k++) begin
      word(32'(k));
      check("t2_fill_level", 32'(fifo_level_o), 32'(k));
    end
    check("t2_head", out_data_o, 32'd8);
    word(32'd5);
    check("t2_pend_level", 32'(fifo_level_o), 32'd4);
    check("t2_pend_head",  out_data_o,        32'd8);
    samp(32'h9); samp(32'h9);
    check("t2_stall_level", 32'(fifo_level_o), 32'd4);
    out_ready_i = 1'b1;
    samp(32'h9);
    out_ready_i = 1'b0;
    check("t2_pop_level", 32'(fifo_level_o), 32'd4);
    check("t2_pop_head",  out_data_o,        32'd16);
    word(32'd6);
    check("t2_pend2_level", 32'(fifo_level_o), 32'd4);
    exp_head[0] = 32'd24; exp_head[1] = 32'd32; exp_head[2] = 32'd40;
    exp_head[3] = 32'd48; exp_head[4] = 32'd0;
    en_i = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_drain_head",  out_data_o,        exp_head[i]);
      check("t2_drain_level", 32'(fifo_level_o), (i == 0) ? 32'd4 : 32'(4 - i));
    end

    // Full FIFO: pop and push on the same edge
    out_ready_i = 1'b0;
    en_i = 1'b1;
    step();
    for (int k = 1; k <= 4; k++) word(32'(k));
    check("t6_full_level", 32'(fifo_level_o), 32'd4);
    samp(32'h7); samp(32'h0); samp(32'h0);
    out_ready_i = 1'b1;
    samp(32'h0);
    out_ready_i = 1'b0;
    check("t6_pp_level", 32'(fifo_level_o), 32'd4);
    check("t6_pp_head",  out_data_o,        32'd16);
    exp_head[0] = 32'd24; exp_head[1] = 32'd32; exp_head[2] = 32'd56; exp_head[3] = 32'd0;
    en_i = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_drain_head", out_data_o, exp_head[i]);
    end

    // Stuck source held at 0xDEADBEEF
    out_ready_i = 1'b0;
    en_i = 1'b1;
    step();
    word(32'd1);
    check("t3_pre_level", 32'(fifo_level_o), 32'd1);
    for (int i = 0; i < 7; i++) samp(32'hDEAD_BEEF);
    check("t3_7_fail",  32'(health_fail_o), 32'd0);
    check("t3_7_level", 32'(fifo_level_o),  32'd2);
    samp(32'hDEAD_BEEF);
`ifdef RNG_RCT_EN
    check("t3_fail",  32'(health_fail_o), 32'd1);
    check("t3_level", 32'(fifo_level_o),  32'd0);
    check("t3_valid", 32'(out_valid_o),   32'd0);
    check("t3_data",  out_data_o,         32'd0);
    step();
    check("t3_halt_fail",  32'(health_fail_o), 32'd1);
    check("t3_halt_valid", 32'(out_valid_o),   32'd0);
    clr_fail_i = 1'b1;
    step();
    clr_fail_i = 1'b0;
    check("t3_clr_fail", 32'(health_fail_o), 32'd0);
    step();
    samp(32'h1); samp(32'h2);
    samp(32'h1); samp(32'h10); samp(32'h100);
    check("t3_rewarm_valid", 32'(out_valid_o), 32'd0);
    samp(32'h1000);
    check("t3_rewarm_data", out_data_o, 32'h0000_1248);
    en_i = 1'b0;
    out_ready_i = 1'b1;
    step();
    check("t3_end_level", 32'(fifo_level_o), 32'd0);
`else
    check("t3_nofail",       32'(health_fail_o), 32'd0);
    check("t3_nofail_level", 32'(fifo_level_o),  32'd3);
    en_i = 1'b0;
    out_ready_i = 1'b1;
    step(); step(); step();
    check("t3_end_level", 32'(fifo_level_o), 32'd0);
    clr_fail_i = 1'b1;
    step();
    clr_fail_i = 1'b0;
    check("t3_clr_ignored", 32'(health_fail_o), 32'd0);
`endif

    // Asynchronous reset between edges with three words buffered
    out_ready_i = 1'b0;
    en_i = 1'b1;
    step();
    word(32'd1); word(32'd2); word(32'd3);
    check("t4_pre_level", 32'(fifo_level_o), 32'd3);
    check("t4_pre_head",  out_data_o,        32'd8);
    #3 rst = 1'b0;
    #1;
    check("t4_valid", 32'(out_valid_o),   32'd0);
    check("t4_level", 32'(fifo_level_o),  32'd0);
    check("t4_data",  out_data_o,         32'd0);
    check("t4_fail",  32'(health_fail_o), 32'd0);
    en_i = 1'b0;
    #10 rst = 1'b1;
    step();
    check("t4_post_level", 32'(fifo_level_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
